// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: buffers writes and launches one
// byte at a time, handshaking on the transmitter's active/done strobes.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Wr_En,
  input  logic [7:0]            i_Wr_Byte,
  input  logic                  i_Tx_Enable,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Overflow
);

  // state       | meaning
  // IDLE        | may launch the next byte if data queued and tx enabled
  // WAIT_ACTIVE | launch pulse sent, waiting for transmitter to go busy
  // WAIT_DONE   | transmitter shifting the byte out
  // HOLDOFF     | done seen; wait for it to drop before the next launch
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACTIVE = 2'd1,
    WAIT_DONE   = 2'd2,
    HOLDOFF     = 2'd3
  } drain_state_t;

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  drain_state_t            state;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     count;
  logic [DEPTH_LOG2:0]     count_next;
  logic                    wr_ok;
  logic                    pop;

  // A write while full is dropped even if a pop frees a slot the same cycle.
  assign wr_ok   = i_Wr_En && !o_Full;
  assign pop     = (state == IDLE) && !o_Empty && i_Tx_Enable;
  assign o_Count = count;

  always_comb begin
    count_next = count;
    case ({wr_ok, pop})
      2'b10:   count_next = count + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_next = count - (DEPTH_LOG2 + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (wr_ok) mem[wr_ptr] <= i_Wr_Byte;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      o_Overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count   <= count_next;
      o_Full  <= (count_next == COUNT_FULL);
      o_Empty <= (count_next == '0);
      if (i_Wr_En && o_Full) o_Overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
    end else begin
      o_Tx_DV <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= mem[rd_ptr];
            state     <= WAIT_ACTIVE;
          end
        end
        WAIT_ACTIVE: if (i_Tx_Active) state <= WAIT_DONE;
        WAIT_DONE:   if (i_Tx_Done)   state <= HOLDOFF;
        // Done may linger for several cycles; relaunching early would be lost.
        HOLDOFF:     if (!i_Tx_Done)  state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a 4-clocks-per-bit transmitter model
// and a scoreboard that tracks occupancy and launch order.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       tx_enable = 1'b0;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;

  int passed = 0;
  int total  = 0;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Wr_En     (wr_en),
    .i_Wr_Byte   (wr_byte),
    .i_Tx_Enable (tx_enable),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .o_Full      (full),
    .o_Empty     (empty),
    .o_Count     (count),
    .o_Overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Transmitter model: 10-bit frame, 4 clocks per bit, done held 2 cycles.
  logic       xm_busy = 1'b0;
  logic [9:0] xm_frame = '0;
  logic [9:0] xm_cap = '0;
  logic       tx_serial = 1'b1;
  int         xm_bit = 0;
  int         xm_clk = 0;
  int         xm_done_cnt = 0;

  always @(posedge clk) begin
    if (xm_done_cnt > 0) begin
      xm_done_cnt <= xm_done_cnt - 1;
      if (xm_done_cnt == 1) tx_done <= 1'b0;
    end
    if (!xm_busy) begin
      if (tx_dv) begin
        xm_busy   <= 1'b1;
        tx_active <= 1'b1;
        xm_frame  <= {1'b1, tx_byte, 1'b0};
        tx_serial <= 1'b0;
        xm_bit    <= 0;
        xm_clk    <= 0;
        xm_cap    <= '0;
      end
    end else begin
      if (xm_clk == 1) xm_cap <= {tx_serial, xm_cap[9:1]};
      if (xm_clk == 3) begin
        xm_clk <= 0;
        if (xm_bit == 9) begin
          xm_busy     <= 1'b0;
          tx_active   <= 1'b0;
          tx_serial   <= 1'b1;
          tx_done     <= 1'b1;
          xm_done_cnt <= 2;
        end else begin
          xm_bit    <= xm_bit + 1;
          tx_serial <= xm_frame[1];
          xm_frame  <= {1'b1, xm_frame[9:1]};
        end
      end else begin
        xm_clk <= xm_clk + 1;
      end
    end
  end

  // Scoreboard: accepted writes sampled at the edge, launches and occupancy
  // checked half a cycle later.
  logic [7:0] sb_q[$];
  logic [7:0] log_q[$];
  logic [7:0] sb_exp;
  int  m_cnt = 0;
  bit  pend_wr = 1'b0;
  bit  prev_dv = 1'b0;
  int  sb_err = 0;
  int  cnt_err = 0;
  int  dv_viol = 0;
  int  n_launch = 0;

  always @(posedge clk) begin
    if (!rst && wr_en && m_cnt < 16) begin
      pend_wr = 1'b1;
      sb_q.push_back(wr_byte);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      m_cnt   = 0;
      pend_wr = 1'b0;
      prev_dv = 1'b0;
      sb_q.delete();
    end else begin
      if (tx_dv) begin
        log_q.push_back(tx_byte);
        n_launch++;
        if (prev_dv || tx_active || tx_done) dv_viol++;
        if (sb_q.size() == 0) sb_err++;
        else begin
          sb_exp = sb_q.pop_front();
          if (sb_exp !== tx_byte) sb_err++;
        end
      end
      m_cnt = m_cnt + (pend_wr ? 1 : 0) - (tx_dv ? 1 : 0);
      pend_wr = 1'b0;
      if (int'(count) != m_cnt) cnt_err++;
      prev_dv = tx_dv;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_quiet(input string name, input bit need_empty, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (!xm_busy && !tx_done && !tx_dv && (!need_empty || empty)) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      total++;
      $display("FAIL %s timeout after %0d cycles", name, n);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL rst_full got %b exp 0", full); else passed++;
    total++; if (count !== 5'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b exp 0", overflow); else passed++;
    total++; if (tx_dv !== 1'b0) $display("FAIL rst_dv got %b exp 0", tx_dv); else passed++;
    total++; if (tx_byte !== 8'h00) $display("FAIL rst_byte got %h exp 00", tx_byte); else passed++;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (empty !== 1'b1 || tx_dv !== 1'b0) $display("FAIL post_rst_idle got empty=%b dv=%b exp 1/0", empty, tx_dv); else passed++;
  endtask

  task automatic test_single_byte();
    logic [9:0] exp_frame;
    exp_frame = {1'b1, 8'hA5, 1'b0};
    tx_enable = 1'b1;
    log_q.delete();
    wr_en = 1'b1; wr_byte = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    total++; if (tx_dv !== 1'b0) $display("FAIL sb_dv_n1 got %b exp 0", tx_dv); else passed++;
    total++; if (count !== 5'd1 || empty !== 1'b0) $display("FAIL sb_count_n1 got %0d/%b exp 1/0", count, empty); else passed++;
    @(negedge clk);
    total++; if (tx_dv !== 1'b1) $display("FAIL sb_dv_n2 got %b exp 1", tx_dv); else passed++;
    total++; if (tx_byte !== 8'hA5) $display("FAIL sb_byte got %h exp a5", tx_byte); else passed++;
    total++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL sb_count_n2 got %0d/%b exp 0/1", count, empty); else passed++;
    @(negedge clk);
    total++; if (tx_dv !== 1'b0) $display("FAIL sb_dv_pulse got %b exp 0", tx_dv); else passed++;
    total++; if (tx_byte !== 8'hA5) $display("FAIL sb_byte_held got %h exp a5", tx_byte); else passed++;
    wait_quiet("sb_drain", 1'b1, 200);
    total++; if (xm_cap !== exp_frame) $display("FAIL sb_frame got %b exp %b", xm_cap, exp_frame); else passed++;
    total++; if (log_q.size() != 1) $display("FAIL sb_launches got %0d exp 1", log_q.size()); else passed++;
  endtask

  task automatic test_burst();
    int errs = 0;
    int base = n_launch;
    log_q.delete();
    tx_enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_byte = 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    total++; if (count !== 5'd15 || full !== 1'b0) $display("FAIL burst_count got %0d/%b exp 15/0", count, full); else passed++;
    wait_quiet("burst_drain", 1'b1, 3000);
    total++; if (n_launch - base != 16) $display("FAIL burst_launches got %0d exp 16", n_launch - base); else passed++;
    if (log_q.size() != 16) errs++;
    else for (int k = 0; k < 16; k++) if (log_q[k] !== 8'(k + 1)) errs++;
    total++; if (errs != 0) $display("FAIL burst_order got %0d bad bytes exp 0", errs); else passed++;
    total++; if (dv_viol != 0) $display("FAIL burst_dv_timing got %0d violations exp 0", dv_viol); else passed++;
    total++; if (cnt_err != 0 || sb_err != 0) $display("FAIL burst_scoreboard got cnt_err=%0d sb_err=%0d exp 0/0", cnt_err, sb_err); else passed++;
  endtask

  task automatic test_overflow();
    int errs = 0;
    tx_enable = 1'b0;
    apply_reset();
    log_q.delete();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_byte = 8'h20 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    total++; if (full !== 1'b1 || count !== 5'd16) $display("FAIL ovf_full got %b/%0d exp 1/16", full, count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b exp 0", overflow); else passed++;
    wr_en = 1'b1; wr_byte = 8'hFF;
    @(negedge clk);
    total++; if (overflow !== 1'b1 || count !== 5'd16) $display("FAIL ovf_set got %b/%0d exp 1/16", overflow, count); else passed++;
    // full-cycle write alongside a pop must still be dropped
    wr_byte = 8'hEE; tx_enable = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    total++; if (count !== 5'd15 || full !== 1'b0) $display("FAIL ovf_pop_drop got %0d/%b exp 15/0", count, full); else passed++;
    total++; if (tx_dv !== 1'b1 || tx_byte !== 8'h20) $display("FAIL ovf_first got %b/%h exp 1/20", tx_dv, tx_byte); else passed++;
    wait_quiet("ovf_drain", 1'b1, 3000);
    if (log_q.size() != 16) errs++;
    else for (int k = 0; k < 16; k++) if (log_q[k] !== 8'h20 + 8'(k)) errs++;
    total++; if (errs != 0) $display("FAIL ovf_order got %0d bad bytes exp 0", errs); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else passed++;
  endtask

  task automatic test_flow_control();
    int n = 0;
    tx_enable = 1'b0;
    apply_reset();
    log_q.delete();
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_byte = 8'h30 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (log_q.size() != 0 || count !== 5'd3) $display("FAIL fc_hold got %0d launches/count %0d exp 0/3", log_q.size(), count); else passed++;
    tx_enable = 1'b1;
    while (log_q.size() < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tx_enable = 1'b0;
    if (log_q.size() < 2) begin
      total++;
      $display("FAIL fc_second timeout after %0d cycles", n);
    end
    wait_quiet("fc_byte2", 1'b0, 300);
    repeat (20) @(negedge clk);
    total++; if (log_q.size() != 2 || count !== 5'd1) $display("FAIL fc_paused got %0d launches/count %0d exp 2/1", log_q.size(), count); else passed++;
    total++; if (log_q.size() < 2 || log_q[0] !== 8'h31 || log_q[1] !== 8'h32) $display("FAIL fc_order12 got %0d bytes exp 31,32", log_q.size()); else passed++;
    tx_enable = 1'b1;
    wait_quiet("fc_drain", 1'b1, 300);
    total++; if (log_q.size() != 3 || log_q[2] !== 8'h33) $display("FAIL fc_byte3 got %0d launches exp 3 ending 33", log_q.size()); else passed++;
  endtask

  task automatic test_wrap();
    int errs = 0;
    int cnt_base = cnt_err;
    int sb_base = sb_err;
    tx_enable = 1'b1;
    apply_reset();
    log_q.delete();
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_byte = 8'h80 + 8'(i);
      @(negedge clk);
      if (i % 5 == 4) begin
        wr_en = 1'b0;
        repeat (200) @(negedge clk);
      end
    end
    wr_en = 1'b0;
    wait_quiet("wrap_drain", 1'b1, 3000);
    if (log_q.size() != 40) errs++;
    else for (int k = 0; k < 40; k++) if (log_q[k] !== 8'h80 + 8'(k)) errs++;
    total++; if (errs != 0) $display("FAIL wrap_order got %0d bad/%0d launches exp 0/40", errs, log_q.size()); else passed++;
    total++; if (cnt_err != cnt_base) $display("FAIL wrap_count got %0d mismatching cycles exp 0", cnt_err - cnt_base); else passed++;
    total++; if (sb_err != sb_base || dv_viol != 0) $display("FAIL wrap_scoreboard got sb=%0d dv=%0d exp 0/0", sb_err - sb_base, dv_viol); else passed++;
  endtask

  task automatic test_reset_mid_byte();
    int n = 0;
    int base;
    tx_enable = 1'b1;
    apply_reset();
    for (int i = 1; i <= 2; i++) begin
      wr_en = 1'b1; wr_byte = 8'h40 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    while (!tx_active && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tx_active) begin
      total++;
      $display("FAIL rmb_active timeout after %0d cycles", n);
    end
    #2 rst = 1'b1;
    #1;
    total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) $display("FAIL rmb_fifo got %0d/%b/%b exp 0/1/0", count, empty, full); else passed++;
    total++; if (tx_byte !== 8'h00 || tx_dv !== 1'b0) $display("FAIL rmb_tx got %h/%b exp 00/0", tx_byte, tx_dv); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL rmb_overflow got %b exp 0", overflow); else passed++;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    log_q.delete();
    base = n_launch;
    wait_quiet("rmb_finish", 1'b1, 200);
    repeat (10) @(negedge clk);
    total++; if (n_launch != base || empty !== 1'b1) $display("FAIL rmb_no_launch got %0d launches/empty %b exp 0/1", n_launch - base, empty); else passed++;
    wr_en = 1'b1; wr_byte = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    wait_quiet("rmb_new", 1'b1, 200);
    total++; if (log_q.size() != 1 || log_q[0] !== 8'h55) $display("FAIL rmb_new_byte got %0d launches exp 1 of 55", log_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_flow_control();
    test_wrap();
    test_reset_mid_byte();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 Port: i_Clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: i_Reset  in  1  reset, asynchronous, active-high.
REQ-004 Port: i_Wr_En  in  1  write strobe; one byte per cycle while high.
REQ-005 Port: i_Wr_Byte  in  8  byte to enqueue.
REQ-006 Port: i_Tx_Enable  in  1  flow control (CTS-like); 0 = do not launch new bytes.
REQ-007 Port: i_Tx_Active  in  1  transmitter busy, from downstream UART transmitter.
REQ-008 Port: i_Tx_Done  in  1  transmitter done, from downstream; may stay high 2+ cycles.
REQ-009 Port: o_Tx_DV  out  1  one-cycle launch pulse to the transmitter.
REQ-010 Port: o_Tx_Byte  out  8  byte to transmit, valid while o_Tx_DV high, held afterwards.
REQ-011 Port: o_Full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-012 Port: o_Empty  out  1  FIFO holds 0 bytes.
REQ-013 Port: o_Count  out  DEPTH_LOG2+1  current occupancy.
REQ-014 Port: o_Overflow  out  1  sticky: a write was attempted while full.

Function
REQ-015 Storage: circular buffer, DEPTH_LOG2-bit read/write pointers, wrap modulo depth, occupancy counter DEPTH_LOG2+1 bits.
REQ-016 Write: i_Wr_En=1 and o_Full=0 -> byte stored at wr_ptr, wr_ptr+1, count+1, visible next cycle.
REQ-017 Write while o_Full=1 is dropped, FIFO unchanged, o_Overflow set to 1 next cycle; even if a pop occurs the same cycle.
REQ-018 Pop and write in same cycle (not full): count unchanged, both pointers advance.
REQ-019 o_Full/o_Empty/o_Count are registered functions of the counter, consistent in the same cycle.
REQ-020 Drain FSM states: IDLE, WAIT_ACTIVE, WAIT_DONE, HOLDOFF.
REQ-021 IDLE: if o_Empty=0 and i_Tx_Enable=1 -> o_Tx_DV<=1, o_Tx_Byte<=mem[rd_ptr], pop (rd_ptr+1, count-1), go WAIT_ACTIVE; else stay.
REQ-022 WAIT_ACTIVE: o_Tx_DV<=0 (pulse exactly one cycle); on i_Tx_Active=1 go WAIT_DONE.
REQ-023 WAIT_DONE: on i_Tx_Done=1 go HOLDOFF.
REQ-024 HOLDOFF: on i_Tx_Done=0 go IDLE; guarantees no launch while transmitter is still in its cleanup cycle.
REQ-025 Latency: byte written in cycle N into empty FIFO with FSM in IDLE and i_Tx_Enable=1 -> o_Tx_DV high in cycle N+2.
REQ-026 Back-to-back: next o_Tx_DV no earlier than 1 cycle after the cycle i_Tx_Done is first seen low in HOLDOFF.
REQ-027 i_Tx_Enable is sampled only in IDLE; deasserting it mid-byte does not abort the byte in flight.
REQ-028 Pop occurs only in IDLE launch; FIFO is never popped when o_Empty=1.
REQ-029 Unused FSM encodings return to IDLE next cycle.

Reset
REQ-030 i_Reset=1 immediately (asynchronously) forces: pointers 0, count 0, o_Empty=1, o_Full=0, o_Count=0, o_Overflow=0, o_Tx_DV=0, o_Tx_Byte=0, FSM IDLE.
REQ-031 Reset mid-transfer discards FIFO contents; after release FSM waits in IDLE and ignores any residual i_Tx_Done.
REQ-032 Storage array contents need not be reset.

Verification
REQ-033 Single byte: write 0xA5 at cycle N, model transmitter (CLKS_PER_BIT=4) -> o_Tx_DV one-cycle pulse at N+2 with o_Tx_Byte=0xA5, serial frame 0 10100101(LSB first) 1.
REQ-034 Burst: write 0x01..0x10 back-to-back (DEPTH_LOG2=4) -> o_Full=1 after 16th write with count 16 (less any already popped), all 16 bytes transmitted in order, exactly one o_Tx_DV per byte, none during HOLDOFF.
REQ-035 Overflow: fill FIFO with i_Tx_Enable=0, write 0xFF -> o_Overflow=1, o_Count=16, 0xFF never transmitted; o_Overflow stays 1 until reset.
REQ-036 Flow control: 3 bytes queued, i_Tx_Enable=0 -> no o_Tx_DV; raise i_Tx_Enable -> three bytes sent in order; drop it during byte 2 -> byte 2 completes, byte 3 held.
REQ-037 Wrap/simultaneous: 40 writes interleaved with pops, including write+pop same cycle -> order preserved across pointer wrap, o_Count matches model every cycle.
REQ-038 Reset mid-byte: assert i_Reset while i_Tx_Active=1 -> all outputs at reset values in the same cycle; after release with transmitter finishing, no o_Tx_DV until a new write.
